// File: rtl/hms_time_counter.sv
// BCD HH:MM:SS time-of-day counter advanced by rising edges of the 1 Hz divider level.
// Supports a validated synchronous load; all outputs are registered.
module hms_time_counter #(
    parameter int HOUR_MAX     = 23,
    parameter bit SEC_PULSE_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_1hz,
    input  logic       en,
    input  logic       load,
    input  logic [7:0] load_hh,
    input  logic [7:0] load_mm,
    input  logic [7:0] load_ss,
    output logic [7:0] hour_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       sec_pulse,
    output logic       day_wrap,
    output logic       load_err
);
    localparam logic [7:0] HMAX_BCD = {4'(HOUR_MAX / 10), 4'(HOUR_MAX % 10)};

    logic       tick_q;
    logic       tick;
    logic       sec_wrap, min_wrap, hour_wrap, day_end;
    logic [7:0] sec_nx, min_nx, hour_nx;
    logic [6:0] hh_val;
    logic       load_ok;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign tick = clk_1hz & ~tick_q;

    always_comb begin
        sec_wrap  = (sec_bcd == 8'h59);
        min_wrap  = (min_bcd == 8'h59);
        hour_wrap = (hour_bcd == HMAX_BCD);
        day_end   = sec_wrap & min_wrap & hour_wrap;

        sec_nx  = sec_wrap ? 8'h00 : bcd_inc(sec_bcd);
        min_nx  = min_bcd;
        hour_nx = hour_bcd;
        if (sec_wrap)
            min_nx = min_wrap ? 8'h00 : bcd_inc(min_bcd);
        if (sec_wrap && min_wrap)
            hour_nx = hour_wrap ? 8'h00 : bcd_inc(hour_bcd);
    end

    // Units <= 9 everywhere, tens bounded per field; hours compared as a binary value.
    always_comb begin
        hh_val  = {3'b000, load_hh[7:4]} * 7'd10 + {3'b000, load_hh[3:0]};
        load_ok = (load_hh[7:4] <= 4'd9) && (load_hh[3:0] <= 4'd9) &&
                  (load_mm[7:4] <= 4'd5) && (load_mm[3:0] <= 4'd9) &&
                  (load_ss[7:4] <= 4'd5) && (load_ss[3:0] <= 4'd9) &&
                  (hh_val <= 7'(HOUR_MAX));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q    <= 1'b1;
            hour_bcd  <= 8'h00;
            min_bcd   <= 8'h00;
            sec_bcd   <= 8'h00;
            sec_pulse <= 1'b0;
            day_wrap  <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            tick_q    <= clk_1hz;
            sec_pulse <= 1'b0;
            day_wrap  <= 1'b0;
            load_err  <= 1'b0;
            // A load swallows any coincident tick.
            if (load) begin
                if (load_ok) begin
                    hour_bcd <= load_hh;
                    min_bcd  <= load_mm;
                    sec_bcd  <= load_ss;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (tick && en) begin
                hour_bcd  <= hour_nx;
                min_bcd   <= min_nx;
                sec_bcd   <= sec_nx;
                sec_pulse <= SEC_PULSE_EN;
                day_wrap  <= day_end;
            end
        end
    end
endmodule

// File: tb/tb_hms_time_counter.sv
// Scoreboard bench: a seconds-of-day model predicts each cycle's outputs for a 24 h and a 12 h instance.
module tb_hms_time_counter;
    logic       clk = 1'b0;
    logic       rst, clk_1hz, en, load;
    logic [7:0] load_hh, load_mm, load_ss;
    logic [7:0] hour0, min0, sec0, hour1, min1, sec1;
    logic       sp0, dw0, le0, sp1, dw1, le1;

    typedef struct packed {
        logic [7:0] hh, mm, ss;
        logic       sp, dw, le;
    } exp_t;

    exp_t q0[$], q1[$];
    int   checks = 0, errors = 0;
    int   tsec[2];
    int   hmax[2] = '{23, 11};
    bit   prev_1hz;

    always #5 clk = ~clk;

    hms_time_counter #(.HOUR_MAX(23), .SEC_PULSE_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .clk_1hz(clk_1hz), .en(en), .load(load),
        .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
        .hour_bcd(hour0), .min_bcd(min0), .sec_bcd(sec0),
        .sec_pulse(sp0), .day_wrap(dw0), .load_err(le0));

    hms_time_counter #(.HOUR_MAX(11), .SEC_PULSE_EN(1'b1)) dut12 (
        .clk(clk), .rst(rst), .clk_1hz(clk_1hz), .en(en), .load(load),
        .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
        .hour_bcd(hour1), .min_bcd(min1), .sec_bcd(sec1),
        .sec_pulse(sp1), .day_wrap(dw1), .load_err(le1));

    function automatic int from_bcd(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [7:0] to_bcd(input int x);
        logic [3:0] t, u;
        t = 4'(x / 10);
        u = 4'(x % 10);
        return {t, u};
    endfunction

    function automatic bit load_valid(input int hm, input logic [7:0] h, m, s);
        if (h[7:4] > 9 || h[3:0] > 9 || m[7:4] > 9 || m[3:0] > 9 || s[7:4] > 9 || s[3:0] > 9)
            return 1'b0;
        return from_bcd(h) <= hm && from_bcd(m) < 60 && from_bcd(s) < 60;
    endfunction

    // Reference model: time kept as seconds since midnight.
    always @(posedge clk) begin
        bit   tk;
        exp_t e;
        tk = clk_1hz && !prev_1hz;
        for (int k = 0; k < 2; k++) begin
            e = '0;
            if (rst) begin
                tsec[k] = 0;
            end else if (load) begin
                if (load_valid(hmax[k], load_hh, load_mm, load_ss))
                    tsec[k] = from_bcd(load_hh) * 3600 + from_bcd(load_mm) * 60 + from_bcd(load_ss);
                else
                    e.le = 1'b1;
            end else if (tk && en) begin
                e.sp = 1'b1;
                tsec[k] = tsec[k] + 1;
                if (tsec[k] == (hmax[k] + 1) * 3600) begin
                    tsec[k] = 0;
                    e.dw = 1'b1;
                end
            end
            e.hh = to_bcd(tsec[k] / 3600);
            e.mm = to_bcd((tsec[k] / 60) % 60);
            e.ss = to_bcd(tsec[k] % 60);
            if (k == 0) q0.push_back(e); else q1.push_back(e);
        end
        prev_1hz = rst ? 1'b1 : clk_1hz;
    end

    task automatic compare(input string name, input exp_t exp, input exp_t act);
        checks++;
        if (exp !== act) begin
            errors++;
            $display("FAIL %s t=%0t got %h:%h:%h sp=%b dw=%b le=%b want %h:%h:%h sp=%b dw=%b le=%b",
                     name, $time, act.hh, act.mm, act.ss, act.sp, act.dw, act.le,
                     exp.hh, exp.mm, exp.ss, exp.sp, exp.dw, exp.le);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            compare("hm23", e, {hour0, min0, sec0, sp0, dw0, le0});
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            compare("hm11", e, {hour1, min1, sec1, sp1, dw1, le1});
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int hi, input int lo);
        @(negedge clk); clk_1hz = 1'b1;
        idle(hi);
        clk_1hz = 1'b0;
        idle(lo);
    endtask

    task automatic do_load(input logic [7:0] h, m, s);
        @(negedge clk);
        load = 1'b1; load_hh = h; load_mm = m; load_ss = s;
        @(negedge clk);
        load = 1'b0;
        idle(2);
    endtask

    initial begin
        rst = 1'b1; clk_1hz = 1'b0; en = 1'b1; load = 1'b0;
        load_hh = 8'h00; load_mm = 8'h00; load_ss = 8'h00;
        idle(3);
        rst = 1'b0;
        repeat (3) pulse(4, 4);

        do_load(8'h00, 8'h59, 8'h59); pulse(2, 3);
        do_load(8'h23, 8'h59, 8'h59); pulse(2, 3);
        do_load(8'h11, 8'h59, 8'h59); pulse(2, 3);
        do_load(8'h09, 8'h59, 8'h59); pulse(2, 3);
        do_load(8'h19, 8'h59, 8'h59); pulse(2, 3);
        do_load(8'h05, 8'h10, 8'h5A);
        do_load(8'h24, 8'h10, 8'h20);
        do_load(8'h09, 8'h9A, 8'h00);

        // Load coincident with a clk_1hz rising edge.
        @(negedge clk);
        clk_1hz = 1'b1; load = 1'b1; load_hh = 8'h12; load_mm = 8'h34; load_ss = 8'h56;
        @(negedge clk);
        load = 1'b0;
        idle(3);
        clk_1hz = 1'b0;
        idle(3);

        en = 1'b0;
        repeat (5) pulse(2, 2);
        do_load(8'h07, 8'h08, 8'h09);
        en = 1'b1;
        pulse(20, 4);

        // clk_1hz high across reset release.
        @(negedge clk); rst = 1'b1; clk_1hz = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(6);
        clk_1hz = 1'b0;
        idle(2);

        do_load(8'h05, 8'h06, 8'h07);
        @(negedge clk); rst = 1'b1; clk_1hz = 1'b1;
        @(negedge clk); rst = 1'b0; clk_1hz = 1'b0;
        idle(3);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            clk_1hz = ($urandom_range(0, 2) == 0) ? ~clk_1hz : clk_1hz;
            en      = ($urandom_range(0, 7) != 0);
            rst     = ($urandom_range(0, 499) == 0);
            load    = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) == 0) begin
                load_hh = 8'($urandom); load_mm = 8'($urandom); load_ss = 8'($urandom);
            end else begin
                load_hh = to_bcd($urandom_range(0, 25));
                load_mm = to_bcd($urandom_range(56, 60));
                load_ss = to_bcd($urandom_range(50, 61));
            end
        end
        @(negedge clk);
        rst = 1'b0; load = 1'b0;
        idle(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
